// File: rtl/pri_enc_pkg.sv
// rtl/pri_enc_pkg.sv - shared constants and helpers for the priority-encoder queue
package pri_enc_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Index width for an N-wide request word; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pri_enc_sel.sv
// rtl/pri_enc_sel.sv - rotating highest-set-bit selector over a pending word
module pri_enc_sel
   import pri_enc_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] pending,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot,
   output logic         single
);

   logic [2*N-1:0] dbl;
   logic [W:0]     shamt;
   logic [N-1:0]   rot;
   logic [W-1:0]   hi;
   logic [W:0]     sum;

   // rot[N-1] maps to start, so a highest-set search walks downward from start with wrap.
   assign dbl   = {pending, pending};
   assign shamt = {1'b0, start} + 1'b1;
   assign rot   = N'(dbl >> shamt);

   always_comb begin
      found = 1'b0;
      hi    = '0;
      for (int j = 0; j < N; j++) begin
         if (rot[j]) begin
            found = 1'b1;
            hi    = W'(j);
         end
      end
   end

   always_comb begin
      sum = {1'b0, hi} + {1'b0, start} + 1'b1;
      if (sum >= (W+1)'(N)) begin
         sum = sum - (W+1)'(N);
      end
      idx = W'(sum);
   end

   assign onehot = found ? (N'(1) << idx) : '0;
   assign single = found && ((pending & (pending - N'(1))) == '0);

endmodule

// File: rtl/pri_enc_queue.sv
// rtl/pri_enc_queue.sv - registered priority encoder that serialises a request word into index beats
module pri_enc_queue
   import pri_enc_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int MODE = MODE_FIXED,
   localparam int W    = idx_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         req_valid,
   output logic         req_ready,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_onehot,
   output logic         grant_valid,
   input  logic         grant_ready,
   output logic         last,
   output logic         zero_err
);

   logic [N-1:0] pending;
   logic [W-1:0] ptr;
   logic [W-1:0] start;
   logic         sel_found;
   logic [W-1:0] sel_idx;
   logic [N-1:0] sel_onehot;
   logic         sel_single;
   logic         accept;
   logic         slot_free;
   logic         load;

   assign req_ready = (pending == '0);
   assign accept    = req_valid && req_ready;
   assign slot_free = !grant_valid || grant_ready;
   assign load      = sel_found && slot_free;
   assign start     = (MODE == MODE_RR) ? ptr : W'(N-1);

   pri_enc_sel #(
      .N (N),
      .W (W)
   ) u_sel (
      .pending (pending),
      .start   (start),
      .found   (sel_found),
      .idx     (sel_idx),
      .onehot  (sel_onehot),
      .single  (sel_single)
   );

   // accept and load are exclusive: accept needs pending empty, load needs it non-empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending      <= '0;
         grant_idx    <= '0;
         grant_onehot <= '0;
         grant_valid  <= 1'b0;
         last         <= 1'b0;
         zero_err     <= 1'b0;
         ptr          <= W'(N-1);
      end else begin
         zero_err <= accept && (req == '0);
         if (accept) begin
            pending <= req;
         end else if (load) begin
            pending <= pending & ~sel_onehot;
         end
         if (load) begin
            grant_idx    <= sel_idx;
            grant_onehot <= sel_onehot;
            grant_valid  <= 1'b1;
            last         <= sel_single;
            if (MODE == MODE_RR) begin
               ptr <= (sel_idx == '0) ? W'(N-1) : sel_idx - W'(1);
            end
         end else if (grant_valid && grant_ready) begin
            grant_onehot <= '0;
            grant_valid  <= 1'b0;
            last         <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pri_enc_queue.sv
// tb/tb_pri_enc_queue.sv - scoreboard bench for fixed and round-robin pri_enc_queue instances
module tb_pri_enc_queue;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0] req_a [3];
   logic       req_valid_a [3];
   logic       grant_ready_a [3];

   logic       rr0, rr1, rr2, gv0, gv1, gv2, la0, la1, la2, ze0, ze1, ze2;
   logic [2:0] gi0, gi1, gi2;
   logic [7:0] oh0, oh1;
   logic [4:0] oh2;

   logic       req_ready_a [3];
   logic       grant_valid_a [3];
   logic       last_a [3];
   logic       zero_err_a [3];
   logic [2:0] idx_a [3];
   logic [7:0] oh_a [3];

   assign req_ready_a[0] = rr0;  assign req_ready_a[1] = rr1;  assign req_ready_a[2] = rr2;
   assign grant_valid_a[0] = gv0; assign grant_valid_a[1] = gv1; assign grant_valid_a[2] = gv2;
   assign last_a[0] = la0;       assign last_a[1] = la1;       assign last_a[2] = la2;
   assign zero_err_a[0] = ze0;   assign zero_err_a[1] = ze1;   assign zero_err_a[2] = ze2;
   assign idx_a[0] = gi0;        assign idx_a[1] = gi1;        assign idx_a[2] = gi2;
   assign oh_a[0] = oh0;         assign oh_a[1] = oh1;         assign oh_a[2] = {3'b000, oh2};

   pri_enc_queue #(.N(8), .MODE(0)) u_fix (
      .clk(clk), .rst_n(rst_n), .req(req_a[0]), .req_valid(req_valid_a[0]), .req_ready(rr0),
      .grant_idx(gi0), .grant_onehot(oh0), .grant_valid(gv0), .grant_ready(grant_ready_a[0]),
      .last(la0), .zero_err(ze0));

   pri_enc_queue #(.N(8), .MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req_a[1]), .req_valid(req_valid_a[1]), .req_ready(rr1),
      .grant_idx(gi1), .grant_onehot(oh1), .grant_valid(gv1), .grant_ready(grant_ready_a[1]),
      .last(la1), .zero_err(ze1));

   pri_enc_queue #(.N(5), .MODE(1)) u_rr5 (
      .clk(clk), .rst_n(rst_n), .req(req_a[2][4:0]), .req_valid(req_valid_a[2]), .req_ready(rr2),
      .grant_idx(gi2), .grant_onehot(oh2), .grant_valid(gv2), .grant_ready(grant_ready_a[2]),
      .last(la2), .zero_err(ze2));

   int checks = 0;
   int failures = 0;
   int n_of [3];
   int mode_of [3];
   int ptr_m [3];
   int grants [3];
   int exp_q [3][$];
   bit prev_stall [3];
   int prev_idx [3];
   int prev_oh [3];
   int prev_last [3];
   int mon_e;
   int base;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference order: walk downward from the start point with wrap, first set bit wins.
   function automatic void push_word(input int i, input int w);
      int pend;
      int st;
      int j;
      int c;
      pend = w;
      while (pend != 0) begin
         st = (mode_of[i] != 0) ? ptr_m[i] : n_of[i] - 1;
         j = -1;
         for (int k = 0; k < n_of[i]; k++) begin
            c = st - k;
            if (c < 0) c = c + n_of[i];
            if (j < 0 && ((pend >> c) & 1) == 1) j = c;
         end
         pend = pend & ~(1 << j);
         exp_q[i].push_back(((pend == 0) ? 256 : 0) + j);
         if (mode_of[i] != 0) ptr_m[i] = (j == 0) ? n_of[i] - 1 : j - 1;
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_onehot", i), int'(oh_a[i]),
                  grant_valid_a[i] ? (1 << idx_a[i]) : 0);
            if (grant_valid_a[i]) check($sformatf("u%0d_idx_range", i), int'(idx_a[i] < n_of[i]), 1);
            if (prev_stall[i]) begin
               check($sformatf("u%0d_hold_valid", i), int'(grant_valid_a[i]), 1);
               check($sformatf("u%0d_hold_idx", i), int'(idx_a[i]), prev_idx[i]);
               check($sformatf("u%0d_hold_onehot", i), int'(oh_a[i]), prev_oh[i]);
               check($sformatf("u%0d_hold_last", i), int'(last_a[i]), prev_last[i]);
            end
            if (grant_valid_a[i] && grant_ready_a[i]) begin
               grants[i]++;
               if (exp_q[i].size() == 0) begin
                  check($sformatf("u%0d_unexpected_grant", i), int'(idx_a[i]), -1);
               end else begin
                  mon_e = exp_q[i].pop_front();
                  check($sformatf("u%0d_grant_idx", i), int'(idx_a[i]), mon_e & 255);
                  check($sformatf("u%0d_grant_last", i), int'(last_a[i]), mon_e >> 8);
               end
            end
            prev_stall[i] = grant_valid_a[i] && !grant_ready_a[i];
            prev_idx[i]   = int'(idx_a[i]);
            prev_oh[i]    = int'(oh_a[i]);
            prev_last[i]  = int'(last_a[i]);
         end
      end else begin
         for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
      end
   end

   task automatic send(input int i, input int w);
      int t;
      t = 0;
      while (!req_ready_a[i] && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check($sformatf("u%0d_req_ready_wait", i), 0, 1);
      req_a[i] = 8'(w);
      req_valid_a[i] = 1'b1;
      push_word(i, w);
      @(posedge clk); #1;
      req_valid_a[i] = 1'b0;
   endtask

   task automatic drain(input int i);
      int t;
      t = 0;
      while ((exp_q[i].size() != 0 || grant_valid_a[i]) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) check($sformatf("u%0d_drain_timeout", i), 0, 1);
   endtask

   initial begin
      n_of = '{8, 8, 5};
      mode_of = '{0, 1, 1};
      for (int i = 0; i < 3; i++) begin
         ptr_m[i] = n_of[i] - 1;
         grants[i] = 0;
         prev_stall[i] = 1'b0;
         req_a[i] = '0;
         req_valid_a[i] = 1'b0;
         grant_ready_a[i] = 1'b1;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("u%0d_rst_valid", i), int'(grant_valid_a[i]), 0);
         check($sformatf("u%0d_rst_onehot", i), int'(oh_a[i]), 0);
         check($sformatf("u%0d_rst_idx", i), int'(idx_a[i]), 0);
         check($sformatf("u%0d_rst_last", i), int'(last_a[i]), 0);
         check($sformatf("u%0d_rst_zero_err", i), int'(zero_err_a[i]), 0);
         check($sformatf("u%0d_rst_req_ready", i), int'(req_ready_a[i]), 1);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fixed priority, latency and last/req_ready timing.
      send(0, 8'hA6);
      check("t1_valid_at_accept", int'(grant_valid_a[0]), 0);
      check("t1_busy_at_accept", int'(req_ready_a[0]), 0);
      @(posedge clk); #1;
      check("t1_first_valid", int'(grant_valid_a[0]), 1);
      check("t1_first_idx", int'(idx_a[0]), 7);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t1_idx2", int'(idx_a[0]), 2);
      check("t1_idx2_last", int'(last_a[0]), 0);
      check("t1_idx2_busy", int'(req_ready_a[0]), 0);
      @(posedge clk); #1;
      check("t1_idx1", int'(idx_a[0]), 1);
      check("t1_idx1_last", int'(last_a[0]), 1);
      check("t1_ready_back", int'(req_ready_a[0]), 1);
      drain(0);

      // Round-robin ordering across words.
      send(1, 8'hFF); drain(1);
      send(1, 8'h81); drain(1);
      send(1, 8'h80); drain(1);
      send(1, 8'h90); drain(1);

      // Back-pressure mid-word.
      base = grants[0];
      send(0, 8'hDA);
      @(posedge clk); #1;
      @(posedge clk); #1;
      grant_ready_a[0] = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      grant_ready_a[0] = 1'b1;
      drain(0);
      check("t3_grant_count", grants[0] - base, 5);

      // All-zero word.
      send(0, 0);
      check("t4_zero_err_pulse", int'(zero_err_a[0]), 1);
      check("t4_ready_held", int'(req_ready_a[0]), 1);
      check("t4_no_grant", int'(grant_valid_a[0]), 0);
      @(posedge clk); #1;
      check("t4_zero_err_clear", int'(zero_err_a[0]), 0);
      check("t4_no_grant_late", int'(grant_valid_a[0]), 0);

      // Reset after two of five grants.
      send(1, 8'h6D);
      repeat (3) begin @(posedge clk); #1; end
      grant_ready_a[1] = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("t5_valid", int'(grant_valid_a[1]), 0);
      check("t5_onehot", int'(oh_a[1]), 0);
      check("t5_req_ready", int'(req_ready_a[1]), 1);
      rst_n = 1'b1;
      grant_ready_a[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q[i].delete();
         ptr_m[i] = n_of[i] - 1;
      end
      @(posedge clk); #1;
      check("t5_req_ready_after", int'(req_ready_a[1]), 1);
      check("t5_quiet_after", int'(grant_valid_a[1]), 0);
      send(1, 8'h81); drain(1);

      // N=5 round-robin wrap.
      send(2, 5'h1F); drain(2);
      send(2, 5'h1F); drain(2);
      send(2, 5'h15); drain(2);

      for (int i = 0; i < 3; i++) check($sformatf("u%0d_queue_empty", i), exp_q[i].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pri_enc_queue.md
Name: pri_enc_queue

Overview:
- Parametrised, registered successor to the combinational 8-to-3 priority encoder.
- Captures an N-bit request word and serialises every set bit into a stream of encoded indices, one per accepted output beat.
- Ordering is either fixed (highest index first) or round-robin (rotating start point).
- Sits between status/interrupt collectors and single-consumer servicing logic; valid/ready on both sides.

Parameters:
- N, 8, request width; must be ≥ 2.
- MODE, 0, ordering: 0 = fixed priority (highest set index first); 1 = round-robin (search starts one below the last granted index, wrapping N-1 after 0).
- W, $clog2(N), index width; derived localparam, not overridable.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst_n  in  1  Reset, synchronous, active-low.
- req  in  N  Request word; bit i set = index i needs service.
- req_valid  in  1  req is presented this cycle.
- req_ready  out  1  Block can accept a new word; high iff the pending register is zero.
- grant_idx  out  W  Encoded index of the current grant.
- grant_onehot  out  N  One-hot form of grant_idx; all-zero when grant_valid = 0.
- grant_valid  out  1  grant_idx/grant_onehot are valid.
- grant_ready  in  1  Consumer accepts the grant this cycle.
- last  out  1  Qualified by grant_valid; current grant is the final bit of its word.
- zero_err  out  1  One-cycle pulse; an all-zero word was accepted.

Behaviour:
- State:
  - pending[N-1:0]
  - output register: idx, onehot, valid, last
  - ptr[W-1:0], search start, used only when MODE = 1
- Reset (rst_n = 0 at an edge), which also aborts any in-progress word:
  - pending = 0, grant_valid = 0, grant_onehot = 0, grant_idx = 0, last = 0, zero_err = 0, ptr = N-1.
  - req_ready reads 1 in the cycle after reset is released.
  - No partial grants survive reset.
- Accept: when req_valid & req_ready, pending <= req at the edge.
  - If req == 0: pending stays 0, zero_err = 1 for one cycle, no grant is produced.
- Load output: at an edge where pending != 0 and the output slot is free, the selected bit moves to the output register and is cleared from pending in the same edge.
  - The slot is free when grant_valid = 0, or when grant_valid & grant_ready.
- Latency:
  - Word accepted at edge k: first grant_valid visible after edge k+1.
  - With grant_ready held high: one grant per cycle, no bubbles.
  - Word with B set bits occupies the output for exactly B consecutive beats.
- Hold: while grant_valid & !grant_ready, grant_idx, grant_onehot, last and pending stay stable.
- last = 1 when the bit loaded was the only remaining bit in pending.
- req_ready rises the cycle after the last bit leaves pending, which can be while the final grant is still waiting in the output register.
  - A new word may therefore be accepted while that final grant stalls, which gives overlap.
- Fixed mode (MODE = 0): select the highest set index of pending; ptr is unused.
- Round-robin mode (MODE = 1):
  - Search downward from ptr, wrapping N-1 after 0; the first set bit wins.
  - On load, ptr <= granted_idx - 1 modulo N (index 0 → N-1).
  - ptr persists across words and is cleared only by reset.
- Simultaneous events: accepting a new word and the output handshake completing in the same edge are legal and independent. The new word cannot collide with an in-flight pending word, because req_ready requires pending == 0.
- N not a power of 2: indices ≥ N never appear; the wrap uses N-1, not 2^W - 1.

Decomposition:
- Shared package (pri_enc_pkg):
  - MODE_FIXED = 0, MODE_RR = 1 constants
  - clog2-based width function, if not already provided
- One natural sub-module: pri_enc_sel.
  - Combinational parametrised selector: inputs pending and start index; outputs found, idx, onehot, single.
  - Implemented as rotate, highest-set search, un-rotate.
  - Instantiated once; MODE_FIXED ties start to N-1.

Test Plan:
1. N=8, MODE=0; accept 8'b1010_0110 with grant_ready=1:
   - grants idx 7, 5, 2, 1 on consecutive cycles
   - first grant one cycle after accept
   - last=1 only on idx 1
   - req_ready returns 1 the cycle after idx 1 is loaded
2. N=8, MODE=1; words 8'hFF then 8'b1000_0001 after ptr reaches 7 again, then 8'b1001_0000 after a grant of idx 7:
   - ptr after 7 is 6
   - second word order is 0 before 7 only when ptr starts below 7: verify ordering 7,0 from ptr=7 and 4,7 from ptr=6
3. Back-pressure: grant_ready=0 for 3 cycles mid-word:
   - grant_idx, grant_onehot and last are held
   - no bit is lost or duplicated
   - total grants equal popcount(req)
4. Accept req=0:
   - zero_err pulses once
   - grant_valid stays 0
   - req_ready stays 1
5. Reset asserted (rst_n=0) for one edge mid-word after 2 of 5 grants:
   - grant_valid=0, req_ready=1, ptr=N-1 afterwards
   - next word starts fresh
6. N=5, MODE=1; req=5'b11111:
   - order 4,3,2,1,0 then wrap
   - no index ≥ 5 ever produced; grant_onehot always matches grant_idx
